// File: rtl/eth_pkg.sv
// eth_pkg: shared framing constants, state encoding and the
// nibble-wide reflected CRC-32 step used by the MII transmit path.
package eth_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_SFD  = 3'd2,
    ST_DATA = 3'd3,
    ST_PAD  = 3'd4,
    ST_FCS  = 3'd5,
    ST_IFG  = 3'd6
  } eth_state_e;

  localparam logic [3:0]  PREAMBLE_NIB = 4'h5;
  localparam logic [3:0]  SFD_NIB      = 4'hD;
  localparam logic [31:0] CRC32_POLY   = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT   = 32'hFFFFFFFF;
  localparam int          PRE_NIBBLES  = 15;

  // One nibble of the LSB-first CRC-32, bit 0 of the nibble first.
  function automatic logic [31:0] crc32_nib(
    input logic [31:0] crc,
    input logic [3:0]  nib
  );
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 4; i++) begin
      if (c[0] ^ nib[i]) c = (c >> 1) ^ CRC32_POLY;
      else               c = c >> 1;
    end
    return c;
  endfunction

endpackage

// File: rtl/eth_crc32_nib.sv
// eth_crc32_nib: registered CRC-32 accumulator fed one nibble per
// enable, re-seeded to all ones by reset or init.
module eth_crc32_nib
  import eth_pkg::*;
(
  input  logic        mainclk,
  input  logic        rst,
  input  logic        i_init,
  input  logic        i_en,
  input  logic [3:0]  i_nib,
  output logic [31:0] o_crc
);

  logic [31:0] r_crc;

  // Seed on reset/init, otherwise fold in one nibble per enable.
  always_ff @(posedge mainclk) begin
    if (rst || i_init) r_crc <= CRC32_INIT;
    else if (i_en)     r_crc <= crc32_nib(r_crc, i_nib);
  end

  assign o_crc = r_crc;

endmodule

// File: rtl/mii_frame_tx.sv
// mii_frame_tx: byte stream to MII nibble framer (preamble, SFD,
// data, zero pad, optional FCS, IFG). Macro MII_FRAME_TX_FCS_EN adds FCS.
module mii_frame_tx
  import eth_pkg::*;
#(
  parameter int MIN_FRAME   = 60,
  parameter int IFG_NIBBLES = 24
) (
  input  logic       mainclk,
  input  logic       rst,
  input  logic       nib_stb,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic [3:0] eth_txd,
  output logic       eth_tx_en,
  output logic       busy,
  output logic       underrun
);

  localparam logic [2:0] S_IDLE = ST_IDLE;
  localparam logic [2:0] S_PRE  = ST_PRE;
  localparam logic [2:0] S_SFD  = ST_SFD;
  localparam logic [2:0] S_DATA = ST_DATA;
  localparam logic [2:0] S_PAD  = ST_PAD;
  localparam logic [2:0] S_FCS  = ST_FCS;
  localparam logic [2:0] S_IFG  = ST_IFG;

`ifdef MII_FRAME_TX_FCS_EN
  localparam logic [2:0] S_TAIL = S_FCS;
`else
  localparam logic [2:0] S_TAIL = S_IFG;
`endif

  logic [2:0]  r_state;
  logic        r_phase;
  logic [3:0]  r_hi;
  logic        r_last;
  logic [10:0] r_bcnt;
  logic [15:0] r_scnt;
  logic [3:0]  r_txd;
  logic        r_txen;
  logic        r_underrun;

  logic        w_load;
  logic        w_short;
  logic [10:0] w_bcnt_inc;
  logic [3:0]  w_fcs_nib;

  assign w_load     = (r_state == S_DATA) && !r_phase;
  assign w_bcnt_inc = (r_bcnt == 11'h7FF) ? r_bcnt
                                          : r_bcnt + 11'd1;
  assign w_short    = int'({21'd0, r_bcnt}) < MIN_FRAME;

`ifdef MII_FRAME_TX_FCS_EN
  logic        w_crc_init;
  logic        w_crc_en;
  logic [3:0]  w_crc_nib;
  logic [31:0] w_crc;

  assign w_crc_init = nib_stb && (r_state == S_SFD);
  assign w_crc_en   = nib_stb &&
                      (((r_state == S_DATA) && (r_phase || s_valid)) ||
                       (r_state == S_PAD));
  assign w_crc_nib  = (r_state != S_DATA) ? 4'h0 :
                      (r_phase ? r_hi : s_data[3:0]);

  eth_crc32_nib u_crc (
    .mainclk (mainclk),
    .rst     (rst),
    .i_init  (w_crc_init),
    .i_en    (w_crc_en),
    .i_nib   (w_crc_nib),
    .o_crc   (w_crc)
  );

  // FCS goes out complemented, least significant nibble first.
  assign w_fcs_nib = ~w_crc[{r_scnt[2:0], 2'b00} +: 4];
`else
  assign w_fcs_nib = 4'h0;
`endif

  // Framing FSM; all MII outputs move only on nibble slots.
  always_ff @(posedge mainclk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_phase    <= 1'b0;
      r_hi       <= 4'h0;
      r_last     <= 1'b0;
      r_bcnt     <= 11'd0;
      r_scnt     <= 16'd0;
      r_txd      <= 4'h0;
      r_txen     <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_underrun <= 1'b0;
      if (nib_stb) begin
        unique case (r_state)
          S_IDLE: begin
            if (s_valid) begin
              r_txen  <= 1'b1;
              r_txd   <= PREAMBLE_NIB;
              r_scnt  <= 16'd1;
              r_state <= S_PRE;
            end else begin
              r_txen <= 1'b0;
              r_txd  <= 4'h0;
            end
          end
          S_PRE: begin
            r_txen <= 1'b1;
            r_txd  <= PREAMBLE_NIB;
            r_scnt <= r_scnt + 16'd1;
            if (r_scnt == 16'(PRE_NIBBLES - 1))
              r_state <= S_SFD;
          end
          S_SFD: begin
            r_txen  <= 1'b1;
            r_txd   <= SFD_NIB;
            r_phase <= 1'b0;
            r_last  <= 1'b0;
            r_bcnt  <= 11'd0;
            r_state <= S_DATA;
          end
          S_DATA: begin
            if (!r_phase) begin
              if (s_valid) begin
                r_txen  <= 1'b1;
                r_txd   <= s_data[3:0];
                r_hi    <= s_data[7:4];
                r_last  <= s_last;
                r_bcnt  <= w_bcnt_inc;
                r_phase <= 1'b1;
              end else begin
                r_txen     <= 1'b0;
                r_txd      <= 4'h0;
                r_underrun <= 1'b1;
                r_scnt     <= 16'd0;
                r_state    <= S_IFG;
              end
            end else begin
              r_txen  <= 1'b1;
              r_txd   <= r_hi;
              r_phase <= 1'b0;
              r_scnt  <= 16'd0;
              if (r_last)
                r_state <= w_short ? S_PAD : S_TAIL;
            end
          end
          S_PAD: begin
            r_txen  <= 1'b1;
            r_txd   <= 4'h0;
            r_phase <= !r_phase;
            r_scnt  <= 16'd0;
            if (!r_phase)
              r_bcnt <= w_bcnt_inc;
            else if (!w_short)
              r_state <= S_TAIL;
          end
          S_FCS: begin
`ifdef MII_FRAME_TX_FCS_EN
            r_txen <= 1'b1;
            r_txd  <= w_fcs_nib;
            r_scnt <= r_scnt + 16'd1;
            if (r_scnt[2:0] == 3'd7) begin
              r_scnt  <= 16'd0;
              r_state <= S_IFG;
            end
`else
            r_txen  <= 1'b0;
            r_txd   <= w_fcs_nib;
            r_scnt  <= 16'd0;
            r_state <= S_IFG;
`endif
          end
          S_IFG: begin
            r_txen <= 1'b0;
            r_txd  <= 4'h0;
            r_scnt <= r_scnt + 16'd1;
            if (r_scnt == 16'(IFG_NIBBLES - 1))
              r_state <= S_IDLE;
          end
          default: begin
            r_txen  <= 1'b0;
            r_txd   <= 4'h0;
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign s_ready   = nib_stb && w_load;
  assign eth_txd   = r_txd;
  assign eth_tx_en = r_txen;
  assign busy      = (r_state != S_IDLE);
  assign underrun  = r_underrun;

endmodule

// File: tb/tb_mii_frame_tx.sv
// tb_mii_frame_tx: directed frames against a byte-level frame model
// (preamble, pad, bytewise CRC-32, gap) checked slot by slot.
module tb_mii_frame_tx;

  localparam int TB_MIN = 60;
  localparam int TB_IFG = 24;
`ifdef MII_FRAME_TX_FCS_EN
  localparam bit TB_FCS = 1'b1;
`else
  localparam bit TB_FCS = 1'b0;
`endif

  logic       mainclk;
  logic       rst;
  logic       nib_stb;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_last;
  logic       s_ready;
  logic [3:0] eth_txd;
  logic       eth_tx_en;
  logic       busy;
  logic       underrun;

  mii_frame_tx #(
    .MIN_FRAME   (TB_MIN),
    .IFG_NIBBLES (TB_IFG)
  ) dut (
    .mainclk   (mainclk),
    .rst       (rst),
    .nib_stb   (nib_stb),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_last    (s_last),
    .s_ready   (s_ready),
    .eth_txd   (eth_txd),
    .eth_tx_en (eth_tx_en),
    .busy      (busy),
    .underrun  (underrun)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0] exp_q[$];
  int         exp_len[$];
  logic [3:0] cap [0:31];
  bit         in_frame = 1'b0;
  bit         discard  = 1'b0;
  int         cur_len  = 0;
  int         last_len = 0;
  int         idle_cnt = 0;
  int         last_gap = 0;

  initial begin
    mainclk = 1'b0;
    forever #5 mainclk = ~mainclk;
  end

  // MII slot strobe: one cycle in four.
  initial begin
    int k;
    k = 0;
    nib_stb = 1'b0;
    forever begin
      @(posedge mainclk);
      #1;
      k = (k + 1) % 4;
      nib_stb = (k == 0);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired n_tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] crc_bytes(input logic [7:0] b[$]);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (b[i]) begin
      c = c ^ {24'h0, b[i]};
      for (int k = 0; k < 8; k++)
        c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  // Expected wire image of a frame; ntake bytes only when truncated.
  task automatic model_frame(input logic [7:0] d[$], input int ntake,
                             input bit full);
    logic [7:0]  b[$];
    logic [31:0] fcs;
    int          len;
    for (int k = 0; k < 15; k++) exp_q.push_back(4'h5);
    exp_q.push_back(4'hD);
    b = {};
    if (full) begin
      b = d;
      while (b.size() < TB_MIN) b.push_back(8'h00);
    end else begin
      for (int k = 0; k < ntake; k++) b.push_back(d[k]);
    end
    foreach (b[k]) begin
      exp_q.push_back(b[k][3:0]);
      exp_q.push_back(b[k][7:4]);
    end
    len = 16 + 2 * b.size();
    if (full && TB_FCS) begin
      fcs = ~crc_bytes(b);
      for (int k = 0; k < 8; k++) exp_q.push_back(fcs[4*k +: 4]);
      len = len + 8;
    end
    exp_len.push_back(len);
  endtask

  // Slot-by-slot compare against the model queues.
  initial begin
    bit stb_s;
    bit rst_s;
    forever begin
      @(posedge mainclk);
      stb_s = nib_stb;
      rst_s = rst;
      #2;
      if (stb_s && !rst_s) begin
        if (eth_tx_en) begin
          if (!in_frame) begin
            in_frame = 1'b1;
            cur_len  = 0;
            last_gap = idle_cnt;
          end
          if (cur_len < 32) cap[cur_len] = eth_txd;
          cur_len++;
          if (exp_q.size() == 0) chk("nib_unexpected", 1, 0);
          else chk("nibble", int'(eth_txd), int'(exp_q.pop_front()));
        end else begin
          chk("idle_txd", int'(eth_txd), 0);
          if (in_frame) begin
            in_frame = 1'b0;
            idle_cnt = 1;
            last_len = cur_len;
            if (discard) begin
              exp_q.delete();
              exp_len.delete();
              discard = 1'b0;
            end else if (exp_len.size() == 0) begin
              chk("len_unexpected", 1, 0);
            end else begin
              chk("frame_len", cur_len, exp_len.pop_front());
            end
          end else begin
            idle_cnt++;
          end
        end
      end
    end
  end

  // Present a frame; optionally starve at byte drop_at or reset at rst_at.
  task automatic send_frame(input logic [7:0] d[$], input int drop_at,
                            input int rst_at, input bit keep);
    int i;
    int guard;
    int n;
    bit hs;
    i = 0;
    guard = 0;
    s_data  = d[0];
    s_last  = (d.size() == 1);
    s_valid = 1'b1;
    while (i < d.size() && guard < 5000) begin
      if (i == drop_at) begin
        s_valid = 1'b0;
        s_last  = 1'b0;
        n = 0;
        do begin
          @(negedge mainclk);
          n++;
        end while (!s_ready && n < 200);
        chk("load_slot_timeout", int'(n >= 200), 0);
        @(posedge mainclk); #1;
        chk("underrun_pulse", int'(underrun), 1);
        chk("underrun_txen", int'(eth_tx_en), 0);
        @(posedge mainclk); #1;
        chk("underrun_single", int'(underrun), 0);
        n = 0;
        guard = 0;
        while (busy && guard < 1000) begin
          @(posedge mainclk);
          if (nib_stb) n++;
          #1;
          guard++;
        end
        chk("underrun_ifg_slots", n, TB_IFG);
        return;
      end
      if (i == rst_at) begin
        discard = 1'b1;
        rst = 1'b1;
        @(posedge mainclk); #1;
        rst = 1'b0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        chk("rst_txen", int'(eth_tx_en), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ready", int'(s_ready), 0);
        return;
      end
      @(negedge mainclk);
      hs = s_valid && s_ready;
      chk("ready_off_slot", int'(s_ready && !nib_stb), 0);
      @(posedge mainclk); #1;
      guard++;
      if (hs) begin
        i++;
        if (i < d.size()) begin
          s_data = d[i];
          s_last = (i == d.size() - 1);
        end else if (!keep) begin
          s_valid = 1'b0;
          s_last  = 1'b0;
        end
      end
    end
    chk("send_timeout", int'(i < d.size()), 0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || in_frame) && n < 20000) begin
      @(posedge mainclk); #1;
      n++;
    end
    chk("drain_timeout", int'(n >= 20000), 0);
    chk("drain_queue", exp_q.size(), 0);
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] q2[$];
    rst = 1'b1;
    s_data = 8'h00;
    s_valid = 1'b0;
    s_last = 1'b0;
    repeat (6) @(posedge mainclk);
    #1;
    chk("reset_txen", int'(eth_tx_en), 0);
    chk("reset_txd", int'(eth_txd), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_ready", int'(s_ready), 0);
    chk("reset_underrun", int'(underrun), 0);
    rst = 1'b0;
    repeat (4) @(posedge mainclk);
    #1;

    // CRC model pinned to the standard "123456789" check value.
    q = {};
    for (int k = 0; k < 9; k++) q.push_back(8'(8'h31 + k));
    if (TB_FCS)
      chk("crc_model_check", int'(~crc_bytes(q)), int'(32'hCBF43926));

    // Single byte frame, padded to the minimum.
    q = {};
    q.push_back(8'hAB);
    model_frame(q, 0, 1'b1);
    send_frame(q, -1, -1, 1'b0);
    wait_idle();
    chk("one_byte_len", last_len, TB_FCS ? 144 : 136);
    chk("one_byte_pre0", int'(cap[0]), 5);
    chk("one_byte_pre14", int'(cap[14]), 5);
    chk("one_byte_sfd", int'(cap[15]), 13);
    chk("one_byte_lo", int'(cap[16]), 11);
    chk("one_byte_hi", int'(cap[17]), 10);
    chk("one_byte_pad", int'(cap[18]), 0);

    // "123456789", padded.
    q = {};
    for (int k = 0; k < 9; k++) q.push_back(8'(8'h31 + k));
    model_frame(q, 0, 1'b1);
    send_frame(q, -1, -1, 1'b0);
    wait_idle();
    chk("ascii_data0", int'(cap[16]), 1);
    chk("ascii_data1", int'(cap[17]), 3);

    // 64-byte frame: no pad.
    q = {};
    for (int k = 0; k < 64; k++) q.push_back(8'(k * 7 + 3));
    model_frame(q, 0, 1'b1);
    send_frame(q, -1, -1, 1'b0);
    wait_idle();
    chk("len64", last_len, TB_FCS ? 152 : 144);

    // Pad boundary: exactly the minimum, and one short of it.
    q = {};
    for (int k = 0; k < 60; k++) q.push_back(8'(8'hF0 ^ k));
    model_frame(q, 0, 1'b1);
    send_frame(q, -1, -1, 1'b0);
    wait_idle();
    chk("len60", last_len, TB_FCS ? 144 : 136);
    q = {};
    for (int k = 0; k < 59; k++) q.push_back(8'(k * 13));
    model_frame(q, 0, 1'b1);
    send_frame(q, -1, -1, 1'b0);
    wait_idle();
    chk("len59", last_len, TB_FCS ? 144 : 136);

    // Starve the fifth load slot.
    q = {};
    for (int k = 0; k < 10; k++) q.push_back(8'(8'h80 + k));
    model_frame(q, 4, 1'b0);
    send_frame(q, 4, -1, 1'b0);
    wait_idle();
    chk("underrun_len", last_len, 24);

    // Reset in the middle of the data, then a clean frame.
    q = {};
    for (int k = 0; k < 10; k++) q.push_back(8'(8'h5A + k));
    model_frame(q, 10, 1'b0);
    send_frame(q, -1, 3, 1'b0);
    repeat (12) @(posedge mainclk);
    #1;
    chk("rst_queue_clear", exp_q.size(), 0);
    q = {};
    for (int k = 0; k < 5; k++) q.push_back(8'(8'hC3 + k));
    model_frame(q, 0, 1'b1);
    send_frame(q, -1, -1, 1'b0);
    wait_idle();
    chk("post_rst_pre0", int'(cap[0]), 5);
    chk("post_rst_sfd", int'(cap[15]), 13);

    // Back to back with s_valid held high.
    q = {};
    for (int k = 0; k < 20; k++) q.push_back(8'(8'h11 * k));
    q2 = {};
    for (int k = 0; k < 70; k++) q2.push_back(8'(255 - k));
    model_frame(q, 0, 1'b1);
    send_frame(q, -1, -1, 1'b1);
    model_frame(q2, 0, 1'b1);
    send_frame(q2, -1, -1, 1'b0);
    wait_idle();
    chk("b2b_gap", last_gap, 24);
    chk("b2b_len", last_len, TB_FCS ? 164 : 156);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mii_frame_tx.md
MII_FRAME_TX -- requirements
Module: mii_frame_tx

Interface
REQ-001 Parameter MIN_FRAME, default 60, minimum bytes (data+pad) before FCS; shorter frames are zero-padded.
REQ-002 Parameter IFG_NIBBLES, default 24, inter-frame gap in nibble slots.
REQ-003 mainclk  in  1  system clock, 100 MHz.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 nib_stb  in  1  one-mainclk pulse per MII nibble slot, synchronised from eth_tx_clk outside this block.
REQ-006 s_data  in  8  payload byte, destination MAC first.
REQ-007 s_valid  in  1  s_data valid.
REQ-008 s_last  in  1  s_data is final payload byte of frame.
REQ-009 s_ready  out  1  byte accepted this cycle when s_valid&s_ready.
REQ-010 eth_txd  out  4  MII transmit nibble, registered.
REQ-011 eth_tx_en  out  1  MII transmit enable, registered.
REQ-012 busy  out  1  high whenever state is not IDLE.
REQ-013 underrun  out  1  one-cycle pulse when a frame is aborted for missing data.

Function
REQ-014 States: IDLE, PRE, SFD, DATA, PAD, FCS, IFG; eth_txd/eth_tx_en update only on nib_stb cycles.
REQ-015 IDLE->PRE on the first nib_stb with s_valid=1; that slot drives eth_tx_en=1, eth_txd=0x5.
REQ-016 PRE: 15 slots total of 0x5 (including REQ-015 slot); SFD: one slot of 0xD; then DATA.
REQ-017 s_ready = nib_stb & load slot; load slot = first DATA slot and every second DATA slot after it while last byte not yet taken; s_ready=0 otherwise.
REQ-018 Load slot with s_valid=1: drive s_data[3:0], hold s_data[7:4] for next slot (low nibble first).
REQ-019 Load slot with s_valid=0: eth_tx_en=0, underrun pulse, go IFG; no FCS sent.
REQ-020 11-bit byte counter counts data+pad bytes, saturates at 2047.
REQ-021 After high nibble of s_last byte: PAD if count<MIN_FRAME, else FCS (or IFG per REQ-029).
REQ-022 PAD: zero bytes (two 0x0 slots each) until count==MIN_FRAME.
REQ-023 CRC-32: reflected poly 0xEDB88320, init 0xFFFFFFFF, over data+pad nibbles; FCS = complement, 8 slots, least significant nibble first.
REQ-024 IFG: eth_tx_en=0, eth_txd=0 for IFG_NIBBLES slots, then IDLE; s_valid ignored in IFG.
REQ-025 s_last with s_valid on a load slot is honoured even if count is 0 (1-byte frame padded).
REQ-026 s_ready never asserted outside DATA; bytes presented in IDLE are not consumed until DATA.

Reset
REQ-027 rst: state IDLE, eth_tx_en=0, eth_txd=0, s_ready=0, busy=0, underrun=0, counters and CRC cleared (CRC to 0xFFFFFFFF) on next mainclk edge.
REQ-028 rst mid-frame truncates immediately; no FCS, no IFG, underrun not pulsed.

Configuration
REQ-029 Macro MII_FRAME_TX_FCS_EN: defined -> FCS state and CRC logic present per REQ-023; undefined -> no CRC logic, DATA/PAD go directly to IFG, frame ends after last data/pad nibble.

Structure
REQ-030 Package eth_pkg: state enum, PREAMBLE_NIB=0x5, SFD_NIB=0xD, CRC32_POLY, CRC32_INIT, PRE_NIBBLES=15.
REQ-031 Sub-module eth_crc32_nib: registered 32-bit CRC, 4-bit input, enable and init; instantiated only under MII_FRAME_TX_FCS_EN.

Verification
REQ-032 MIN_FRAME=0, FCS_EN, send ASCII "123456789" -> 15x0x5, 0xD, nibbles 1,3,2,3..9,3, FCS nibbles 6,2,9,3,4,F,B,C, then 24 idle slots.
REQ-033 Default params, 1-byte frame 0xAB -> nibbles B,A then 118 zero nibbles, then 8 FCS nibbles; eth_tx_en high for exactly 16+120+8=144 slots.
REQ-034 Drop s_valid at 5th load slot -> eth_tx_en low on that slot, underrun single pulse, busy low 24 slots later.
REQ-035 rst asserted during DATA -> next cycle eth_tx_en=0, busy=0, s_ready=0; following frame starts with full preamble.
REQ-036 Back-to-back frames with s_valid held high -> exactly 24 idle slots between last FCS nibble and next preamble.
REQ-037 FCS_EN undefined, 64-byte frame -> eth_tx_en high exactly 16+128 slots, no trailing nibbles.
